lsu_port: RTL and testbench

Load/store unit that sits directly upstream of the dual-port BRAM memory interface and drives one of its ports (normally port B, data side). It accepts one RV32 load or store request at a time from the execute stage and generates byte enables and lane-aligned store data. For loads, it waits for the memory's tagged read-valid return, then extracts and sign/zero-extends the result and hands it to writeback. Requests are strictly serialised: one in flight, no overlap.

---
 rtl/lsu_port.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_port.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port.sv
// Load/store port: serialises one RV32 load or store at a time onto a BRAM port,
// lane-aligning store data and extracting/extending tagged load returns.
module lsu_port #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_raddr,
  input  logic        mem_accept_read,
  input  logic        mem_accept_write,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both high; the requester holds its fields stable until then. Responses
  // are a one-cycle resp_valid pulse with no backpressure.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_word_addr;
  logic [31:0] r_din;
  logic [4:0]  r_rd;
  logic [3:0]  r_tmo;
  logic        r_resp_valid;
  logic [4:0]  r_resp_rd;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  logic        w_req_legal;
  logic        w_req_misal;
  logic        w_req_bad;
  logic [31:0] w_req_din;
  logic [3:0]  w_st_be;
  logic [31:0] w_ld_shift;
  logic [31:0] w_ld_data;
  logic        w_accept;
  logic        w_issue_fire;
  logic        w_rd_match;
  logic [3:0]  w_tmo_next;
  logic        w_tmo_hit;

  always_comb begin : req_decode
    w_req_legal = 1'b0;
    if (req_we) begin
      w_req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
    end else begin
      w_req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
    end

    // funct3[1:0] encodes the access size for every legal load and store
    w_req_misal = 1'b0;
    w_req_din   = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_req_misal = 1'b0;
        w_req_din   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_req_misal = req_addr[0];
        w_req_din   = {2{req_wdata[15:0]}};
      end
      default: begin
        w_req_misal = (req_addr[1:0] != 2'b00);
        w_req_din   = req_wdata;
      end
    endcase

    w_req_bad = !w_req_legal || w_req_misal;
  end

  always_comb begin : store_be
    w_st_be = 4'b1111;
    case (r_funct3[1:0])
      2'b00:   w_st_be = 4'b0001 << r_off;
      2'b01:   w_st_be = 4'b0011 << r_off;
      default: w_st_be = 4'b1111;
    endcase
  end

  always_comb begin : load_extract
    w_ld_shift = mem_dout >> {r_off, 3'b000};
    w_ld_data  = mem_dout;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
      3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
      default: w_ld_data = mem_dout;
    endcase
  end

  assign w_accept     = r_we ? mem_accept_write : mem_accept_read;
  assign w_issue_fire = (r_state == S_ISSUE) && w_accept;
  assign w_rd_match   = mem_rvalid && (mem_raddr == r_word_addr);
  assign w_tmo_next   = r_tmo + 4'd1;
  assign w_tmo_hit    = (w_tmo_next == TMO);

  // Enables follow the accept inputs within the issuing cycle, so they are not registered
  assign mem_en    = !rst && (w_issue_fire || (r_state == S_WAIT_RD));
  assign mem_we    = (!rst && w_issue_fire && r_we) ? w_st_be : 4'b0000;
  assign mem_addr  = r_word_addr;
  assign mem_din   = r_din;
  assign req_ready = !rst && (r_state == S_IDLE);
  assign busy      = !rst && (r_state != S_IDLE);
  assign dbg_state = r_state;

  assign resp_valid = r_resp_valid;
  assign resp_rd    = r_resp_rd;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_word_addr  <= 32'd0;
      r_din        <= 32'd0;
      r_rd         <= 5'd0;
      r_tmo        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_rd    <= 5'd0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_off       <= req_addr[1:0];
            r_word_addr <= {2'b00, req_addr[31:2]};
            r_din       <= req_we ? w_req_din : 32'd0;
            r_rd        <= req_rd;
            if (w_req_bad) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rd    <= 5'd0;
              r_resp_data  <= 32'd0;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            if (r_we) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rd    <= 5'd0;
              r_resp_data  <= 32'd0;
            end else begin
              r_state <= S_WAIT_RD;
              r_tmo   <= 4'd0;
            end
          end
        end
        S_WAIT_RD: begin
          // A matching return wins over a timeout landing in the same cycle
          if (w_rd_match) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rd    <= r_rd;
            r_resp_data  <= w_ld_data;
          end else if (w_tmo_hit) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rd    <= 5'd0;
            r_resp_data  <= 32'd0;
          end else begin
            r_tmo <= w_tmo_next;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_resp_rd   <= 5'd0;
          r_resp_data <= 32'd0;
          r_resp_err  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port: hand-computed vectors plus a reference model of
// RV32 load/store lane rules feeding a scoreboard that watches every cycle.
module tb_lsu_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_raddr = 32'd0;
  logic        mem_accept_read = 1'b1;
  logic        mem_accept_write = 1'b1;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  lsu_port #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_rvalid(mem_rvalid), .mem_raddr(mem_raddr),
    .mem_accept_read(mem_accept_read), .mem_accept_write(mem_accept_write),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % ref_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    b = ((1 << ref_size(f3)) - 1) << (addr % 4);
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_din(input logic [2:0] f3, input logic [31:0] wdata);
    case (ref_size(f3))
      1:       return (wdata & 32'hFF) * 32'h01010101;
      2:       return (wdata & 32'hFFFF) * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] dout);
    int     sz;
    longint v;
    sz = ref_size(f3);
    v  = longint'(dout) >> (8 * (addr % 4));
    v  = v % (longint'(1) << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- scoreboard ----------------
  // resp entry: {rd[4:0], data[31:0], err}; write entry: {be[3:0], din[31:0]}
  logic [37:0] exp_q[$];
  logic [35:0] exp_wr_q[$];
  logic [31:0] exp_addr = 32'd0;
  bit          sb_on = 1'b0;

  always begin : compare
    logic [37:0] e;
    logic [35:0] w;
    @(negedge clk);
    #1;
    if (sb_on && !rst) begin
      chk("sb_ready_vs_busy", req_ready, !busy);
      if (mem_en) chk("sb_mem_addr", mem_addr, exp_addr);
      if (mem_we != 4'd0) begin
        chk("sb_we_without_en", mem_en, 1'b1);
        if (exp_wr_q.size() == 0) begin
          chk("sb_unexpected_write", mem_we, 4'd0);
        end else begin
          w = exp_wr_q.pop_front();
          chk("sb_mem_we", mem_we, w[35:32]);
          chk("sb_mem_din", mem_din, w[31:0]);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_resp", resp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_resp_rd", resp_rd, e[37:33]);
          chk("sb_resp_data", resp_data, e[32:1]);
          chk("sb_resp_err", resp_err, e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    int n;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rd     = rd;
    exp_addr   = addr >> 2;
    if (!ref_legal(we, f3) || ref_misal(f3, addr)) begin
      exp_q.push_back({5'd0, 32'd0, 1'b1});
    end else if (we) begin
      exp_wr_q.push_back({ref_be(f3, addr), ref_din(f3, wdata)});
      exp_q.push_back({5'd0, 32'd0, 1'b0});
    end
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_accept_timeout", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_return(input logic [31:0] dout, input logic [31:0] raddr);
    mem_rvalid = 1'b1;
    mem_dout   = dout;
    mem_raddr  = raddr;
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] x_we,
                           input logic [31:0] x_addr, input logic [31:0] x_din);
    mem_accept_write = 1'b1;
    do_req(1'b1, f3, addr, wdata, 5'd3);
    chk({name, "_en"}, mem_en, 1'b1);
    chk({name, "_we"}, mem_we, x_we);
    chk({name, "_addr"}, mem_addr, x_addr);
    chk({name, "_din"}, mem_din, x_din);
    @(negedge clk);
    chk({name, "_resp_valid"}, resp_valid, 1'b1);
    chk({name, "_resp_rd"}, resp_rd, 5'd0);
    chk({name, "_resp_err"}, resp_err, 1'b0);
    chk({name, "_en_off"}, mem_en, 1'b0);
    @(negedge clk);
    chk({name, "_resp_once"}, resp_valid, 1'b0);
    chk({name, "_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] dout,
                          input logic [31:0] x_data);
    mem_accept_read = 1'b1;
    do_req(1'b0, f3, addr, 32'd0, rd);
    chk({name, "_en"}, mem_en, 1'b1);
    chk({name, "_we0"}, mem_we, 4'd0);
    chk({name, "_addr"}, mem_addr, addr >> 2);
    @(negedge clk);
    chk({name, "_wait_en"}, mem_en, 1'b1);
    exp_q.push_back({rd, ref_load(f3, addr, dout), 1'b0});
    mem_return(dout, addr >> 2);
    chk({name, "_resp_valid"}, resp_valid, 1'b1);
    chk({name, "_resp_rd"}, resp_rd, rd);
    chk({name, "_resp_data"}, resp_data, x_data);
    chk({name, "_resp_err"}, resp_err, 1'b0);
    @(negedge clk);
    chk({name, "_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic run_err(input string name, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr);
    do_req(we, f3, addr, 32'h12345678, 5'd7);
    chk({name, "_resp_valid"}, resp_valid, 1'b1);
    chk({name, "_resp_err"}, resp_err, 1'b1);
    chk({name, "_resp_data"}, resp_data, 32'd0);
    chk({name, "_resp_rd"}, resp_rd, 5'd0);
    chk({name, "_no_en"}, mem_en, 1'b0);
    @(negedge clk);
    chk({name, "_resp_once"}, resp_valid, 1'b0);
    chk({name, "_ready_back"}, req_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    int n_en;

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", mem_en, 1'b0);
    chk("rst_we", mem_we, 4'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_resp", {resp_valid, resp_rd, resp_data, resp_err}, 39'd0);
    rst = 1'b0;
    sb_on = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

    // stores
    run_store("sb_1003", 3'b000, 32'h1003, 32'h000000AB, 4'b1000, 32'h400, 32'hABABABAB);
    run_store("sh_0102", 3'b001, 32'h0102, 32'h1234CAFE, 4'b1100, 32'h40, 32'hCAFECAFE);
    run_store("sw_0200", 3'b010, 32'h0200, 32'h11223344, 4'b1111, 32'h80, 32'h11223344);
    run_store("sb_0005", 3'b000, 32'h0005, 32'h00000055, 4'b0010, 32'h1, 32'h55555555);

    // loads
    run_load("lb_2001",  3'b000, 32'h2001, 5'd5, 32'h123480FF, 32'hFFFFFF80);
    run_load("lbu_2001", 3'b100, 32'h2001, 5'd5, 32'h123480FF, 32'h00000080);
    run_load("lh_0006",  3'b001, 32'h0006, 5'd6, 32'h80011234, 32'hFFFF8001);
    run_load("lhu_0006", 3'b101, 32'h0006, 5'd6, 32'h80011234, 32'h00008001);
    run_load("lb_0000",  3'b000, 32'h0000, 5'd1, 32'h0000007F, 32'h0000007F);
    run_load("lh_0004",  3'b001, 32'h0004, 5'd31, 32'h1234F00D, 32'hFFFFF00D);

    // decode errors
    run_err("lh_misal", 1'b0, 3'b001, 32'h0003);
    run_err("ld_f3_011", 1'b0, 3'b011, 32'h0010);
    run_err("sw_misal", 1'b1, 3'b010, 32'h0102);
    run_err("st_f3_100", 1'b1, 3'b100, 32'h0000);

    // read stall, then a mismatched tag, then the matching return
    mem_accept_read = 1'b0;
    do_req(1'b0, 3'b010, 32'h0040, 32'd0, 5'd12);
    chk("stall_c1_en", mem_en, 1'b0);
    @(negedge clk);
    chk("stall_c2_en", mem_en, 1'b0);
    @(negedge clk);
    chk("stall_c3_en", mem_en, 1'b0);
    chk("stall_busy", busy, 1'b1);
    @(negedge clk);
    mem_accept_read = 1'b1;
    #1;
    chk("stall_issue_en", mem_en, 1'b1);
    @(negedge clk);
    chk("stall_wait_en", mem_en, 1'b1);
    mem_return(32'h55555555, 32'h11);
    chk("mismatch_ignored", resp_valid, 1'b0);
    chk("mismatch_still_wait", mem_en, 1'b1);
    exp_q.push_back({5'd12, ref_load(3'b010, 32'h0040, 32'hDEADBEEF), 1'b0});
    mem_return(32'hDEADBEEF, 32'h10);
    chk("lw_resp_valid", resp_valid, 1'b1);
    chk("lw_resp_data", resp_data, 32'hDEADBEEF);
    chk("lw_resp_rd", resp_rd, 5'd12);
    @(negedge clk);

    // timeout: 15 cycles in WAIT_RD, then an error response
    exp_q.push_back({5'd0, 32'd0, 1'b1});
    do_req(1'b0, 3'b010, 32'h0080, 32'd0, 5'd4);
    chk("tmo_issue_en", mem_en, 1'b1);
    n = 0;
    n_en = 0;
    do begin
      @(negedge clk);
      n++;
      if (!resp_valid && mem_en) n_en++;
    end while (!resp_valid && n < 40);
    chk("tmo_latency", n, 16);
    chk("tmo_wait_cycles", n_en, 15);
    chk("tmo_resp_err", resp_err, 1'b1);
    chk("tmo_resp_rd", resp_rd, 5'd0);
    chk("tmo_ready_during_resp", req_ready, 1'b0);
    @(negedge clk);
    chk("tmo_ready_back", req_ready, 1'b1);

    // reset while waiting for read data
    do_req(1'b0, 3'b010, 32'h0100, 32'd0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_waiting", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", req_ready, 1'b0);
    chk("rstmid_outs", {mem_en, mem_we, mem_addr, mem_din}, 69'd0);
    chk("rstmid_resp", {resp_valid, resp_rd, resp_data, resp_err, busy}, 40'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_wr_q.delete();
    mem_return(32'hCAFEF00D, 32'h40);
    chk("rstmid_no_resp", resp_valid, 1'b0);
    chk("rstmid_ready_back", req_ready, 1'b1);
    chk("rstmid_idle_outs", {mem_en, mem_we, mem_addr, busy}, 38'd0);
    @(negedge clk);
    chk("rstmid_no_resp2", resp_valid, 1'b0);

    // the port works normally after the mid-flight reset
    run_load("lw_after_rst", 3'b010, 32'h0104, 5'd2, 32'h0BADF00D, 32'h0BADF00D);

    repeat (2) @(negedge clk);
    chk("sb_resp_drained", exp_q.size(), 0);
    chk("sb_wr_drained", exp_wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
